// File: rtl/reflet_pkg.sv
// Shared constants for the Reflet 16-bit CPU data bus.
// Word width, default RAM address width and the idle bus value.
package reflet_pkg;

  localparam int WORD_W = 16;
  localparam int RAM_AW = 15;

  localparam logic [WORD_W-1:0] BUS_IDLE = 16'h0000;

  function automatic logic [WORD_W-1:0] bus_gate(
    input logic              sel,
    input logic [WORD_W-1:0] val
  );
    return sel ? val : BUS_IDLE;
  endfunction

endpackage

// File: rtl/reflet_word_ram_if.sv
// CPU-side bus bundle for the Reflet word RAM.
// Master drives the access, slave returns read data.
interface reflet_word_ram_if #(
  parameter int addrSize = reflet_pkg::RAM_AW
) ();

  logic                          enable;
  logic                          write_en;
  logic [addrSize-1:0]           addr;
  logic [reflet_pkg::WORD_W-1:0] data_in;
  logic [reflet_pkg::WORD_W-1:0] data_out;

  modport master (
    output enable,
    output write_en,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  enable,
    input  write_en,
    input  addr,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/reflet_ram_array.sv
// Bare word storage: synchronous write port and registered read port.
// No reset here so the array can map onto block RAM.
module reflet_ram_array
  import reflet_pkg::*;
#(
  parameter int addrSize = RAM_AW,
  parameter int wordSize = WORD_W
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [addrSize-1:0] addr_i,
  input  logic [wordSize-1:0] wdata_i,
  output logic [wordSize-1:0] rdata_o
);

  logic [wordSize-1:0] mem_q [2**addrSize];
  logic [wordSize-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read sees the pre-write contents (read-first)
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/reflet_word_ram.sv
// Reflet data RAM: enable gating, zero-on-deselect, async reset.
// Define REFLET_RAM_WRITE_FIRST_EN for write-first read-during-write.
module reflet_word_ram
  import reflet_pkg::*;
#(
  parameter int addrSize = RAM_AW,
  parameter int wordSize = WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  reflet_word_ram_if.slave   bus
);

  logic                sel_q;
  logic                sel_d;
  logic                acc;
  logic                wr;
  logic [wordSize-1:0] arr_rdata;
  logic [wordSize-1:0] rd_val;

  assign acc   = bus.enable & reset;
  assign wr    = acc & bus.write_en;
  assign sel_d = bus.enable;

  reflet_ram_array #(
    .addrSize (addrSize),
    .wordSize (wordSize)
  ) u_array (
    .clk     (clk),
    .we_i    (wr),
    .re_i    (acc),
    .addr_i  (bus.addr),
    .wdata_i (bus.data_in),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
    end
  end

`ifdef REFLET_RAM_WRITE_FIRST_EN
  logic                byp_q;
  logic                byp_d;
  logic [wordSize-1:0] wbuf_q;
  logic [wordSize-1:0] wbuf_d;

  assign byp_d  = bus.enable & bus.write_en;
  assign wbuf_d = bus.data_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp_q  <= 1'b0;
      wbuf_q <= BUS_IDLE;
    end else begin
      byp_q  <= byp_d;
      wbuf_q <= wbuf_d;
    end
  end

  always_comb begin
    rd_val = arr_rdata;
    if (byp_q) begin
      rd_val = wbuf_q;
    end
  end
`else
  always_comb begin
    rd_val = arr_rdata;
  end
`endif

  // Output depends only on registers, so it never follows addr
  assign bus.data_out = bus_gate(sel_q, rd_val);

endmodule

// File: tb/tb_reflet_word_ram.sv
// Scoreboard bench for reflet_word_ram.
// Driver queues expected data_out per cycle; monitor compares.
module tb_reflet_word_ram;

  logic clk;
  logic rst;

  reflet_word_ram_if bus ();

  reflet_word_ram dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    bit          chk;
    bit          neq;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

`ifdef REFLET_RAM_WRITE_FIRST_EN
  localparam logic [15:0] RDW_EXP = 16'h2222;
`else
  localparam logic [15:0] RDW_EXP = 16'h1111;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       nm,
    input logic [15:0] act,
    input logic [15:0] exp,
    input bit          neq
  );
    n_cmp++;
    if (neq ? (act === exp) : (act !== exp)) begin
      n_bad++;
      $display("FAIL %s: got %h, required %s%h",
               nm, act, neq ? "not " : "", exp);
    end
  endtask

  task automatic cyc(
    input logic        r,
    input logic        en,
    input logic        we,
    input logic [14:0] a,
    input logic [15:0] d,
    input bit          chk,
    input bit          neq,
    input logic [15:0] exp,
    input string       nm
  );
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.enable   = en;
    bus.write_en = we;
    bus.addr     = a;
    bus.data_in  = d;
    e.chk  = chk;
    e.neq  = neq;
    e.exp  = exp;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b1, 1'b1, a, d, 1'b0, 1'b0, 16'h0, "wr");
  endtask

  task automatic rd(
    input logic [14:0] a,
    input logic [15:0] exp,
    input string       nm
  );
    cyc(1'b1, 1'b1, 1'b0, a, 16'h0, 1'b1, 1'b0, exp, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check(e.name, bus.data_out, e.exp, e.neq);
        end
      end
    end
  end

  initial begin : driver
    n_cmp = 0;
    n_bad = 0;
    rst          = 1'b0;
    bus.enable   = 1'b1;
    bus.write_en = 1'b1;
    bus.addr     = 15'h0010;
    bus.data_in  = 16'hBEEF;

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 15'h0010, 16'hBEEF,
          1'b1, 1'b0, 16'h0000, "rst_hold_out");
    end

    cyc(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0,
        1'b1, 1'b1, 16'hBEEF, "rst_no_write");

    wr(15'h0000, 16'h1234);
    wr(15'h7FFF, 16'hABCD);
    rd(15'h0000, 16'h1234, "rd_lo");
    rd(15'h7FFF, 16'hABCD, "rd_hi");

    cyc(1'b1, 1'b0, 1'b0, 15'h0000, 16'h0,
        1'b1, 1'b0, 16'h0000, "deselect");
    cyc(1'b1, 1'b0, 1'b1, 15'h0000, 16'hFFFF,
        1'b1, 1'b0, 16'h0000, "desel_wr_out");
    rd(15'h0000, 16'h1234, "desel_no_write");

    wr(15'h0020, 16'h1111);
    cyc(1'b1, 1'b1, 1'b1, 15'h0020, 16'h2222,
        1'b1, 1'b0, RDW_EXP, "rd_during_wr");
    rd(15'h0020, 16'h2222, "rdw_after");

    wr(15'h0010, 16'h5A5A);
    rd(15'h0010, 16'h5A5A, "post_rst_wr");

    for (int i = 0; i < 16; i++) begin
      wr(15'(15'h0100 + i), 16'(i + 1));
    end
    for (int i = 0; i < 16; i++) begin
      rd(15'(15'h0100 + i), 16'(i + 1), "stream");
    end

    rd(15'h7FFF, 16'hABCD, "pre_async");
    @(posedge clk);
    #3;
    check("pre_async_live", bus.data_out, 16'hABCD, 1'b0);
    rst = 1'b0;
    #1;
    check("async_rst", bus.data_out, 16'h0000, 1'b0);

    cyc(1'b0, 1'b1, 1'b0, 15'h7FFF, 16'h0,
        1'b1, 1'b0, 16'h0000, "async_hold");
    rd(15'h7FFF, 16'hABCD, "after_async");
    cyc(1'b1, 1'b0, 1'b0, 15'h0000, 16'h0,
        1'b1, 1'b0, 16'h0000, "final_idle");

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reflet_word_ram.md
# reflet_word_ram

Single-port, word-wide synchronous RAM for the Reflet 16-bit CPU data bus. It holds the CPU's read/write data region in the upper half of the address map, with the CPU's address MSB as its enable. It drives zero whenever it is not selected, so its output can be OR-combined with ROM and peripheral outputs without a mux. It sits beside the program ROM on the shared CPU bus.

## Interface
Parameters:
- addrSize, 15: number of word-address bits; depth = 2^addrSize 16-bit words.
- wordSize, 16: data width (fixed at 16 for this block, exposed for the package constant).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- enable  in  1  chip select; high = this RAM owns the current bus cycle.
- addr  in  addrSize  word address.
- data_in  in  16  write data.
- write_en  in  1  write strobe, qualified by enable.
- data_out  out  16  read data; 16'h0000 when not selected or in reset.

## Operation
- Write: at rising clk with reset=1, enable=1, write_en=1 → mem[addr] <= data_in.
- Read: at rising clk with reset=1, enable=1 → data_out <= mem[addr], regardless of write_en (read-during-write rule: see Configuration).
- Deselect: at rising clk with enable=0 → data_out <= 0; no memory access. write_en is ignored when enable=0.
- Reset: reset=0 forces data_out to 0 immediately (asynchronously) and holds it there; writes are suppressed while reset=0. Memory contents are not cleared by reset.
- Power-up memory contents are undefined (X in simulation). The bench must write before reading.
- Addresses are full-range; there is no wrap or out-of-range case, since every addrSize-bit value is a valid word.

## Timing
- Read latency: 1 cycle. The address and enable sampled at edge N produce data_out valid after edge N and held until edge N+1.
- Write takes effect at the sampling edge. A read of the same address at edge N+1 or later returns the new value.
- Back-to-back accesses are allowed every cycle with no wait states. There is no handshake.
- Reset release: the first rising edge with reset=1 performs a normal access.
- data_out changes only on a rising clk or an asynchronous reset assertion. It never changes combinationally with addr.

## Configuration
- REFLET_RAM_WRITE_FIRST_EN defined:
  - A simultaneous read and write to the same address (enable=1, write_en=1) returns data_in on data_out after that edge (write-first).
- Not defined:
  - The same access returns the previous mem[addr] contents (read-first).
  - Default build is read-first.

## Structure
- Shared package (reflet_pkg): the word-width constant (16), the default RAM address width (15), and the bus-idle value (16'h0000).
- One natural sub-module: reflet_ram_array, the bare 2^addrSize×16 storage with a synchronous write port and a registered read port. The top level adds enable gating, zero-on-deselect, reset handling and the write-first bypass.

## Test plan
- Reset behaviour: hold reset=0 for 5 cycles with enable=1, write_en=1, addr=0x0010, data_in=0xBEEF. Required: data_out stays 0x0000. After release, a read of 0x0010 does not return 0xBEEF unless it was written after reset.
- Basic read/write: write 0x1234 to 0x0000 and 0xABCD to 0x7FFF, then read both. Required: data_out = 0x1234, then 0xABCD, each one cycle after the address is presented.
- Deselect: set enable=0 with addr=0x0000 after the previous writes. Required: data_out = 0x0000 on the next edge. Also assert write_en=1 with data_in=0xFFFF and enable=0; a later read of 0x0000 must still return 0x1234.
- Read-during-write: mem[0x0020] = 0x1111, then write 0x2222 to 0x0020 with enable=1. Required: data_out = 0x2222 when REFLET_RAM_WRITE_FIRST_EN is defined, otherwise 0x1111. The next read returns 0x2222 in both builds.
- Back-to-back streaming: write 0x0001..0x0010 to addresses 0x0100..0x010F on consecutive cycles, then read them consecutively. Required: the values match in order with exactly 1-cycle latency and no gaps.
- Asynchronous reset mid-read: drop reset low between edges while data_out=0xABCD. Required: data_out = 0x0000 before the next clk edge.
